// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined parametrised FP multiplier with flush-to-zero and five rounding modes
// Optional sticky flag accumulators are enabled by defining FP_MUL_STICKY_FLAGS_EN.
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRC_W  = 23,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 inv
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    input  logic                 flag_clr,
    output logic                 ovrf_stky,
    output logic                 udrf_stky,
    output logic                 inv_stky
`endif
);

    localparam int W      = 1 + EXP_W + FRC_W;
    localparam int MW     = FRC_W + 1;
    localparam int PW     = 2 * MW;
    localparam int EW2    = EXP_W + 2;
    localparam int PL_W   = 1 + 2 + PW + EW2 + 3;
    localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX_I = (1 << EXP_W) - 1;

    localparam logic signed [EW2-1:0] BIAS   = BIAS_I[EW2-1:0];
    localparam logic signed [EW2-1:0] EMAX   = EMAX_I[EW2-1:0];
    localparam logic signed [EW2-1:0] ZERO_S = '0;

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

    logic w_adv;
    logic r_out_valid;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack, classify, sign ----------------
    logic [EXP_W-1:0] w_x_exp, w_y_exp;
    logic [FRC_W-1:0] w_x_frc, w_y_frc;
    logic             w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
    logic [1:0]       w_cls;
    logic [2:0]       w_mode;

    assign w_x_exp  = fp_X[W-2 -: EXP_W];
    assign w_y_exp  = fp_Y[W-2 -: EXP_W];
    assign w_x_frc  = fp_X[FRC_W-1:0];
    assign w_y_frc  = fp_Y[FRC_W-1:0];
    assign w_x_nan  = (&w_x_exp) && (|w_x_frc);
    assign w_y_nan  = (&w_y_exp) && (|w_y_frc);
    assign w_x_inf  = (&w_x_exp) && !(|w_x_frc);
    assign w_y_inf  = (&w_y_exp) && !(|w_y_frc);
    // exp==0 covers both true zero and subnormals, which are flushed here
    assign w_x_zero = ~|w_x_exp;
    assign w_y_zero = ~|w_y_exp;
    assign w_mode   = (r_mode > RM_RMM) ? RM_RNE : r_mode;

    always_comb begin
        w_cls = CLS_NUM;
        if (w_x_nan || w_y_nan)
            w_cls = CLS_NAN;
        else if ((w_x_inf && w_y_zero) || (w_x_zero && w_y_inf))
            w_cls = CLS_NAN;
        else if (w_x_inf || w_y_inf)
            w_cls = CLS_INF;
        else if (w_x_zero || w_y_zero)
            w_cls = CLS_ZERO;
    end

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [1:0]       r_s1_cls;
    logic [MW-1:0]    r_s1_mx, r_s1_my;
    logic [EXP_W-1:0] r_s1_ex, r_s1_ey;
    logic [2:0]       r_s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= CLS_ZERO;
            r_s1_mx    <= '0;
            r_s1_my    <= '0;
            r_s1_ex    <= '0;
            r_s1_ey    <= '0;
            r_s1_mode  <= RM_RNE;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= fp_X[W-1] ^ fp_Y[W-1];
            r_s1_cls   <= w_cls;
            r_s1_mx    <= {1'b1, w_x_frc};
            r_s1_my    <= {1'b1, w_y_frc};
            r_s1_ex    <= w_x_exp;
            r_s1_ey    <= w_y_exp;
            r_s1_mode  <= w_mode;
        end
    end

    // ---------------- S2: mantissa product and exponent sum ----------------
    logic [PW-1:0]         w_m_prod;
    logic signed [EW2-1:0] w_m_esum;
    logic [PL_W-1:0]       w_m_pl;

    assign w_m_prod = {{MW{1'b0}}, r_s1_mx} * {{MW{1'b0}}, r_s1_my};
    assign w_m_esum = $signed({2'b00, r_s1_ex}) + $signed({2'b00, r_s1_ey}) - BIAS;
    assign w_m_pl   = {r_s1_sign, r_s1_cls, w_m_prod, w_m_esum, r_s1_mode};

    logic            w_t_valid;
    logic [PL_W-1:0] w_t_pl;

    // With STAGES==2 the multiplier feeds the final stage combinationally.
    generate
        if (STAGES == 2) begin : g_no_mid
            assign w_t_valid = r_s1_valid;
            assign w_t_pl    = w_m_pl;
        end else begin : g_mid
            localparam int MID = STAGES - 2;
            logic [MID-1:0]  r_mid_valid;
            logic [PL_W-1:0] r_mid_pl [MID];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mid_valid <= '0;
                    for (int i = 0; i < MID; i++) r_mid_pl[i] <= '0;
                end else if (w_adv) begin
                    r_mid_valid[0] <= r_s1_valid;
                    r_mid_pl[0]    <= w_m_pl;
                    for (int i = 1; i < MID; i++) begin
                        r_mid_valid[i] <= r_mid_valid[i-1];
                        r_mid_pl[i]    <= r_mid_pl[i-1];
                    end
                end
            end

            assign w_t_valid = r_mid_valid[MID-1];
            assign w_t_pl    = r_mid_pl[MID-1];
        end
    endgenerate

    // ---------------- last stage: normalise, round, pack, flags ----------------
    logic                  w_t_sign;
    logic [1:0]            w_t_cls;
    logic [PW-1:0]         w_t_prod;
    logic signed [EW2-1:0] w_t_esum;
    logic [2:0]            w_t_mode;

    assign w_t_sign = w_t_pl[PL_W-1];
    assign w_t_cls  = w_t_pl[PL_W-2 -: 2];
    assign w_t_prod = w_t_pl[PL_W-4 -: PW];
    assign w_t_esum = $signed(w_t_pl[3 +: EW2]);
    assign w_t_mode = w_t_pl[2:0];

    logic                  w_hi;
    logic [FRC_W-1:0]      w_mant;
    logic                  w_guard, w_stick, w_inc, w_to_inf;
    logic [MW-1:0]         w_mant_r;
    logic signed [EW2-1:0] w_exp_n, w_exp_r;
    logic                  w_of, w_uf;
    logic [W-1:0]          w_res;
    logic                  w_ovrf, w_udrf, w_inv;

    assign w_hi     = w_t_prod[PW-1];
    assign w_mant   = w_hi ? w_t_prod[PW-2 -: FRC_W] : w_t_prod[PW-3 -: FRC_W];
    assign w_guard  = w_hi ? w_t_prod[PW-2-FRC_W]    : w_t_prod[PW-3-FRC_W];
    // round and lower bits collapse into one sticky bit; decisions only need "any below guard"
    assign w_stick  = w_hi ? (|w_t_prod[PW-3-FRC_W:0]) : (|w_t_prod[PW-4-FRC_W:0]);
    assign w_exp_n  = w_t_esum + $signed({{(EW2-1){1'b0}}, w_hi});

    always_comb begin
        w_inc = 1'b0;
        case (w_t_mode)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = w_t_sign && (w_guard || w_stick);
            RM_RUP:  w_inc = !w_t_sign && (w_guard || w_stick);
            RM_RMM:  w_inc = w_guard;
            default: w_inc = w_guard && (w_stick || w_mant[0]);
        endcase
    end

    assign w_mant_r = {1'b0, w_mant} + {{FRC_W{1'b0}}, w_inc};
    // a carry out of the fraction leaves it all-zero, so only the exponent moves
    assign w_exp_r  = w_exp_n + $signed({{(EW2-1){1'b0}}, w_mant_r[FRC_W]});
    assign w_of     = (w_exp_r >= EMAX);
    assign w_uf     = (w_exp_r <= ZERO_S);

    always_comb begin
        w_to_inf = 1'b1;
        case (w_t_mode)
            RM_RTZ:  w_to_inf = 1'b0;
            RM_RDN:  w_to_inf = w_t_sign;
            RM_RUP:  w_to_inf = !w_t_sign;
            default: w_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        w_res  = '0;
        w_ovrf = 1'b0;
        w_udrf = 1'b0;
        w_inv  = 1'b0;
        case (w_t_cls)
            CLS_NAN: begin
                w_res = QNAN;
                w_inv = 1'b1;
            end
            CLS_INF:  w_res = {w_t_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            CLS_ZERO: w_res = {w_t_sign, {(W-1){1'b0}}};
            default: begin
                if (w_of) begin
                    w_ovrf = 1'b1;
                    if (w_to_inf)
                        w_res = {w_t_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
                    else
                        w_res = {w_t_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
                end else if (w_uf) begin
                    w_udrf = 1'b1;
                    w_res  = {w_t_sign, {(W-1){1'b0}}};
                end else begin
                    w_res = {w_t_sign, w_exp_r[EXP_W-1:0], w_mant_r[FRC_W-1:0]};
                end
            end
        endcase
    end

    logic [W-1:0] r_z;
    logic         r_ovrf, r_udrf, r_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_ovrf      <= 1'b0;
            r_udrf      <= 1'b0;
            r_inv       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_t_valid;
            if (w_t_valid) begin
                r_z    <= w_res;
                r_ovrf <= w_ovrf;
                r_udrf <= w_udrf;
                r_inv  <= w_inv;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign fp_Z      = r_z;
    assign ovrf      = r_ovrf;
    assign udrf      = r_udrf;
    assign inv       = r_inv;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic w_acc;
    logic r_ovrf_stky, r_udrf_stky, r_inv_stky;

    assign w_acc = r_out_valid && out_ready;

    // a setting event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovrf_stky <= 1'b0;
            r_udrf_stky <= 1'b0;
            r_inv_stky  <= 1'b0;
        end else begin
            if (w_acc && r_ovrf)  r_ovrf_stky <= 1'b1;
            else if (flag_clr)    r_ovrf_stky <= 1'b0;
            if (w_acc && r_udrf)  r_udrf_stky <= 1'b1;
            else if (flag_clr)    r_udrf_stky <= 1'b0;
            if (w_acc && r_inv)   r_inv_stky  <= 1'b1;
            else if (flag_clr)    r_inv_stky  <= 1'b0;
        end
    end

    assign ovrf_stky = r_ovrf_stky;
    assign udrf_stky = r_udrf_stky;
    assign inv_stky  = r_inv_stky;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe (W=32, STAGES=3)
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, ovrf, udrf, inv;
    logic [31:0] fp_X, fp_Y, fp_Z;
    logic [2:0]  r_mode;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic        flag_clr, ovrf_stky, udrf_stky, inv_stky;
`endif

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .FRC_W(23), .STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .inv(inv)
`ifdef FP_MUL_STICKY_FLAGS_EN
        , .flag_clr(flag_clr), .ovrf_stky(ovrf_stky), .udrf_stky(udrf_stky), .inv_stky(inv_stky)
`endif
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [34:0] r;
    } vec_t;

    vec_t        vecs[$];
    logic [34:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_res = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic add(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       input logic [31:0] z, input logic [2:0] f);
        vec_t v;
        v.x = x; v.y = y; v.m = m; v.r = {z, f};
        vecs.push_back(v);
    endtask

    // result word compared as {fp_Z, ovrf, udrf, inv}
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0)
                check("unexpected_out", out_valid, 1'b0);
            else if (out_ready) begin
                check($sformatf("res%0d", n_res), {fp_Z, ovrf, udrf, inv}, exp_q.pop_front());
                n_res++;
            end else
                check("held", {fp_Z, ovrf, udrf, inv}, exp_q[0]);
        end
    end

    task automatic run_ops(input int first, input int n, input int st_lo, input int st_hi);
        int k = 0;
        int c = 0;
        while (k < n && c < 200) begin
            fp_X      = vecs[first+k].x;
            fp_Y      = vecs[first+k].y;
            r_mode    = vecs[first+k].m;
            in_valid  = 1'b1;
            out_ready = !(c >= st_lo && c <= st_hi);
            @(negedge clk);
            if (c >= st_lo && c <= st_hi) check("in_ready_stall", in_ready, 1'b0);
            if (in_ready) begin
                exp_q.push_back(vecs[first+k].r);
                k++;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (k < n) check("issue_timeout", k, n);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int lat;
        int seen;
        add(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000);
        add(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 3'b100);
        add(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 3'b100);
        add(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 3'b100);
        add(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 3'b010);
        add(32'h80000001, 32'h3F800000, 3'd0, 32'h80000000, 3'b000);
        add(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b001);
        add(32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 3'b001);
        add(32'h7F7FFFFF, 32'h40000000, 3'd3, 32'h7F800000, 3'b100);
        add(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 3'b100);
        add(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 3'b000);
        add(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 3'b000);
        add(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 3'b000);
        add(32'h3FC00000, 32'h3F800001, 3'd0, 32'h3FC00002, 3'b000);
        add(32'h3FC00000, 32'h3F800001, 3'd1, 32'h3FC00001, 3'b000);
        add(32'h3FC00000, 32'h3F800003, 3'd0, 32'h3FC00004, 3'b000);
        add(32'h3FC00000, 32'h3F800003, 3'd4, 32'h3FC00005, 3'b000);
        add(32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 3'b000);
        add(32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 3'b000);
        add(32'hC0000000, 32'h40400000, 3'd0, 32'hC0C00000, 3'b000);
        add(32'h3FC00000, 32'h3F800001, 3'd7, 32'h3FC00002, 3'b000);
        add(32'h7F7FFFFF, 32'h40000000, 3'd4, 32'h7F800000, 3'b100);
        add(32'hFF7FFFFF, 32'h40000000, 3'd1, 32'hFF7FFFFF, 3'b100);
        add(32'h80000000, 32'h7F800000, 3'd0, 32'h7FC00000, 3'b001);
        add(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 3'b000);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fp_X = '0; fp_Y = '0; r_mode = '0;
`ifdef FP_MUL_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fp_Z", fp_Z, 32'h0);
        check("rst_flags", {ovrf, udrf, inv}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        fp_X = vecs[0].x; fp_Y = vecs[0].y; r_mode = vecs[0].m; in_valid = 1'b1;
        @(negedge clk);
        check("accept0", in_ready, 1'b1);
        exp_q.push_back(vecs[0].r);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3);
        drain();

        run_ops(1, vecs.size() - 1, 999, 998);
        drain();

        run_ops(0, 8, 4, 7);
        drain();

        run_ops(11, 3, 999, 998);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_fp_Z", fp_Z, 32'h0);
        check("midrst_flags", {ovrf, udrf, inv}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale", seen, 0);
        @(posedge clk); #1;

`ifdef FP_MUL_STICKY_FLAGS_EN
        run_ops(1, 1, 999, 998);
        drain();
        @(negedge clk);
        check("ovrf_stky_set", ovrf_stky, 1'b1);
        check("inv_stky_idle", inv_stky, 1'b0);
        @(posedge clk); #1;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        @(negedge clk);
        check("ovrf_stky_clr", ovrf_stky, 1'b0);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
